de4_sopc_pio_in: RTL and testbench

- Avalon-MM slave input port. It is the read-side counterpart of the board LED output port and serves push-buttons and DIP switches on the DE4 SOPC system.
- Samples asynchronous board inputs through a 2-flop synchroniser, detects edges per bit, latches them in a write-1-to-clear edge-capture register, and raises a level interrupt gated by a per-bit mask.
- Sits on the same system interconnect as the other PIO slaves: 2-bit word address, 32-bit data.

---
 rtl/de4_sopc_pio_in_if.sv | 21 ++
 rtl/de4_sopc_pio_in.sv | 131 +++++++++++++
 tb/tb_de4_sopc_pio_in.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/de4_sopc_pio_in_if.sv
// Avalon-MM slave bus bundle for the DE4 SOPC PIO input port.
// Carries the word address, the select and write strobes, the write data,
// the registered read data and the level interrupt.
interface de4_sopc_pio_in_if ();
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/de4_sopc_pio_in.sv
// DE4 SOPC PIO input port: an Avalon-MM slave serving push-buttons and DIP
// switches.
//
// Board inputs pass through a 2-flop synchroniser. Each bit is edge-detected,
// and the edges are latched in a write-1-to-clear edge-capture register. A
// registered level interrupt is raised when any captured bit is also set in
// irqmask.
//
// Register map (word address):
//   0 = input data
//   1 = reserved, reads 0
//   2 = irqmask
//   3 = edgecapture
//
// Optional feature, enabled by the macro DE4_SOPC_PIO_IN_DEBOUNCE_EN: a
// per-bit debounce filter sits between the synchroniser and the edge
// detector. A bit must hold a new value for DEBOUNCE_CYCLES cycles before the
// filtered value follows it.
module de4_sopc_pio_in #(
    parameter int          WIDTH           = 8,
    parameter int          EDGE_TYPE       = 0,
    parameter logic [31:0] IRQ_RESET_MASK  = 32'h0,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    de4_sopc_pio_in_if.slave bus
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] d_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic [31:0]      rd_next;

    // Upper write-data bits beyond WIDTH carry no meaning for this port.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    // Two-flop synchroniser for the asynchronous board inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

`ifdef DE4_SOPC_PIO_IN_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt [WIDTH];

    // Per-bit debounce: f only follows s2 after it has differed for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    f[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // Without the debounce filter the count parameter has no effect.
    localparam int UNUSED_DEBOUNCE = DEBOUNCE_CYCLES;

    assign f = s2;
`endif

    // Select which transition of the filtered input counts as an edge
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = f & ~d_prev;
            1:       edge_det = ~f & d_prev;
            default: edge_det = f ^ d_prev;
        endcase
    end

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign clr   = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    // Read mux from current register values, so a same-cycle write is not visible yet
    always_comb begin
        rd_next = '0;
        case (bus.address)
            2'd0:    rd_next[WIDTH-1:0] = f;
            2'd2:    rd_next[WIDTH-1:0] = irqmask;
            2'd3:    rd_next[WIDTH-1:0] = capture;
            default: rd_next = '0;
        endcase
    end

    // Edge history, sticky capture (set beats clear), mask, interrupt and read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_prev       <= '0;
            capture      <= '0;
            irqmask      <= IRQ_RESET_MASK[WIDTH-1:0];
            bus.irq      <= 1'b0;
            bus.readdata <= '0;
        end else begin
            d_prev  <= f;
            capture <= (capture & ~clr) | edge_det;
            if (wr_en && bus.address == 2'd2) begin
                irqmask <= bus.writedata[WIDTH-1:0];
            end
            bus.irq      <= |(capture & irqmask);
            bus.readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_de4_sopc_pio_in.sv
// Testbench for de4_sopc_pio_in: two instances (rising-edge, any-edge) driven
// from a vector table, with read results checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_de4_sopc_pio_in;

    localparam int WIDTH = 8;
`ifdef DE4_SOPC_PIO_IN_DEBOUNCE_EN
    localparam int EXTRA = 16;
`else
    localparam int EXTRA = 0;
`endif
    localparam int W = 4 + EXTRA;

    typedef enum int {OP_PORT, OP_WAIT, OP_WR, OP_RD, OP_IRQ} op_t;

    typedef struct {
        op_t         op;
        int          sel;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } sb_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [WIDTH-1:0] port [2];
    logic             cs   [2];
    logic             wn   [2];
    logic [1:0]       addr [2];
    logic [31:0]      wd   [2];
    logic [31:0]      rd   [2];
    logic             irq  [2];

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    de4_sopc_pio_in_if bus_a ();
    de4_sopc_pio_in_if bus_b ();

    assign bus_a.address    = addr[0];
    assign bus_a.chipselect = cs[0];
    assign bus_a.write_n    = wn[0];
    assign bus_a.writedata  = wd[0];
    assign rd[0]            = bus_a.readdata;
    assign irq[0]           = bus_a.irq;

    assign bus_b.address    = addr[1];
    assign bus_b.chipselect = cs[1];
    assign bus_b.write_n    = wn[1];
    assign bus_b.writedata  = wd[1];
    assign rd[1]            = bus_b.readdata;
    assign irq[1]           = bus_b.irq;

    de4_sopc_pio_in #(
        .WIDTH(WIDTH), .EDGE_TYPE(0), .IRQ_RESET_MASK(32'h0), .DEBOUNCE_CYCLES(16)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .in_port(port[0]), .bus(bus_a)
    );

    de4_sopc_pio_in #(
        .WIDTH(WIDTH), .EDGE_TYPE(2), .IRQ_RESET_MASK(32'hA5), .DEBOUNCE_CYCLES(16)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .in_port(port[1]), .bus(bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input op_t op, input int sel, input logic [1:0] a,
                                input logic [31:0] d, input logic [31:0] exp);
        vecs.push_back('{op, sel, a, d, exp});
    endfunction

    // Every vector starts and ends at a falling clock edge with the bus idle.
    task automatic run_vec(input int i);
        vec_t v;
        sb_t  e;
        v = vecs[i];
        case (v.op)
            OP_PORT: port[v.sel] = v.d[WIDTH-1:0];
            OP_WAIT: repeat (v.d) @(negedge clk);
            OP_WR: begin
                cs[v.sel] = 1'b1; wn[v.sel] = 1'b0; addr[v.sel] = v.a; wd[v.sel] = v.d;
                @(negedge clk);
                cs[v.sel] = 1'b0; wn[v.sel] = 1'b1;
            end
            OP_RD: begin
                cs[v.sel] = 1'b1; wn[v.sel] = 1'b1; addr[v.sel] = v.a;
                sb.push_back('{v.sel, v.exp, $sformatf("v%0d_rd_dut%0d_a%0d", i, v.sel, v.a)});
                @(negedge clk);
                cs[v.sel] = 1'b0;
                e = sb.pop_front();
                check(e.name, rd[e.sel], e.exp);
            end
            OP_IRQ: check($sformatf("v%0d_irq_dut%0d", i, v.sel), {31'b0, irq[v.sel]}, v.exp);
            default: ;
        endcase
    endtask

    int n_main;
    int n_post;
    sb_t e0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            port[k] = '0; cs[k] = 1'b0; wn[k] = 1'b1; addr[k] = 2'd0; wd[k] = '0;
        end

        // Main vectors, dut 0 = rising edge, dut 1 = any edge with mask reset 0xA5
        add(OP_PORT, 0, 0, 32'h05, 0);
        add(OP_WAIT, 0, 0, W, 0);
        add(OP_RD,   0, 3, 0, 32'h05);
        add(OP_RD,   0, 0, 0, 32'h05);
        add(OP_IRQ,  0, 0, 0, 0);
        add(OP_RD,   0, 2, 0, 32'h00);
        add(OP_RD,   0, 1, 0, 32'h00);
        add(OP_WR,   0, 2, 32'h04, 0);
        add(OP_IRQ,  0, 0, 0, 0);
        add(OP_WAIT, 0, 0, 1, 0);
        add(OP_IRQ,  0, 0, 0, 1);
        add(OP_WR,   0, 3, 32'h04, 0);
        add(OP_IRQ,  0, 0, 0, 1);
        add(OP_WAIT, 0, 0, 1, 0);
        add(OP_IRQ,  0, 0, 0, 0);
        add(OP_RD,   0, 3, 0, 32'h01);
        add(OP_WR,   0, 0, 32'hFF, 0);
        add(OP_WR,   0, 1, 32'hFF, 0);
        add(OP_RD,   0, 2, 0, 32'h04);
        add(OP_RD,   0, 3, 0, 32'h01);
        // rising edge on bit 1 lands on the same clock as a clear of bit 1
        add(OP_PORT, 0, 0, 32'h07, 0);
        add(OP_WAIT, 0, 0, 2 + EXTRA, 0);
        add(OP_WR,   0, 3, 32'h02, 0);
        add(OP_RD,   0, 3, 0, 32'h03);
        add(OP_WR,   0, 3, 32'h03, 0);
        add(OP_RD,   0, 3, 0, 32'h00);
        // falling edges are ignored by the rising-edge instance
        add(OP_PORT, 0, 0, 32'h00, 0);
        add(OP_WAIT, 0, 0, W, 0);
        add(OP_RD,   0, 3, 0, 32'h00);
        add(OP_RD,   0, 0, 0, 32'h00);
        // exact capture latency: not yet visible one cycle early
        add(OP_PORT, 0, 0, 32'h10, 0);
        add(OP_WAIT, 0, 0, 2 + EXTRA, 0);
        add(OP_RD,   0, 3, 0, 32'h00);
        add(OP_RD,   0, 3, 0, 32'h10);
        add(OP_IRQ,  0, 0, 0, 0);
        // unmasking an already captured bit, then masking it again
        add(OP_WR,   0, 2, 32'h14, 0);
        add(OP_IRQ,  0, 0, 0, 0);
        add(OP_WAIT, 0, 0, 1, 0);
        add(OP_IRQ,  0, 0, 0, 1);
        add(OP_WR,   0, 2, 32'h04, 0);
        add(OP_WAIT, 0, 0, 1, 0);
        add(OP_IRQ,  0, 0, 0, 0);
        // any-edge instance: bit 7 high, clear, bit 7 low
        add(OP_PORT, 1, 0, 32'h80, 0);
        add(OP_WAIT, 1, 0, W, 0);
        add(OP_RD,   1, 3, 0, 32'h80);
        add(OP_RD,   1, 0, 0, 32'h80);
        add(OP_RD,   1, 2, 0, 32'hA5);
        add(OP_IRQ,  1, 0, 0, 1);
        add(OP_WR,   1, 3, 32'h80, 0);
        add(OP_RD,   1, 3, 0, 32'h00);
        add(OP_PORT, 1, 0, 32'h00, 0);
        add(OP_WAIT, 1, 0, W, 0);
        add(OP_RD,   1, 3, 0, 32'h80);
        add(OP_RD,   1, 0, 0, 32'h00);
        // load capture 0xFF and mask 0xFF ahead of the mid-operation reset
        add(OP_PORT, 0, 0, 32'h00, 0);
        add(OP_WAIT, 0, 0, W, 0);
        add(OP_WR,   0, 3, 32'hFF, 0);
        add(OP_WR,   0, 2, 32'hFF, 0);
        add(OP_PORT, 0, 0, 32'hFF, 0);
        add(OP_WAIT, 0, 0, W, 0);
        add(OP_RD,   0, 3, 0, 32'hFF);
        add(OP_IRQ,  0, 0, 0, 1);
        n_main = vecs.size();

        // After reset release
        add(OP_WAIT, 0, 0, W + 1, 0);
        add(OP_RD,   0, 3, 0, 32'h00);
        add(OP_RD,   0, 2, 0, 32'h00);
        add(OP_RD,   0, 0, 0, 32'h00);
        add(OP_RD,   1, 3, 0, 32'h01);
        add(OP_RD,   1, 2, 0, 32'hA5);
        add(OP_IRQ,  1, 0, 0, 1);
`ifdef DE4_SOPC_PIO_IN_DEBOUNCE_EN
        add(OP_PORT, 0, 0, 32'h01, 0);
        add(OP_WAIT, 0, 0, 10, 0);
        add(OP_PORT, 0, 0, 32'h00, 0);
        add(OP_WAIT, 0, 0, 30, 0);
        add(OP_RD,   0, 3, 0, 32'h00);
        add(OP_RD,   0, 0, 0, 32'h00);
        add(OP_PORT, 0, 0, 32'h01, 0);
        add(OP_WAIT, 0, 0, 30, 0);
        add(OP_RD,   0, 3, 0, 32'h01);
        add(OP_RD,   0, 0, 0, 32'h01);
`endif
        n_post = vecs.size();

        // Power-on reset
        #3 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_rd_dut0", rd[0], 32'h0);
        check("reset_rd_dut1", rd[1], 32'h0);
        check("reset_irq_dut0", {31'b0, irq[0]}, 32'h0);
        check("reset_irq_dut1", {31'b0, irq[1]}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < n_main; i++) run_vec(i);

        // Read and write of irqmask in the same cycle returns the old value
        cs[0] = 1'b1; wn[0] = 1'b0; addr[0] = 2'd2; wd[0] = 32'h3C;
        sb.push_back('{0, 32'hFF, "same_cycle_rw_old"});
        @(negedge clk);
        cs[0] = 1'b0; wn[0] = 1'b1;
        e0 = sb.pop_front();
        check(e0.name, rd[e0.sel], e0.exp);
        cs[0] = 1'b1; addr[0] = 2'd2;
        sb.push_back('{0, 32'h3C, "same_cycle_rw_new"});
        @(negedge clk);
        cs[0] = 1'b0;
        e0 = sb.pop_front();
        check(e0.name, rd[e0.sel], e0.exp);

        // Asynchronous reset in the middle of a clock period
        check("pre_reset_irq_dut0", {31'b0, irq[0]}, 32'h1);
        check("pre_reset_irq_dut1", {31'b0, irq[1]}, 32'h1);
        #2 reset_n = 1'b0;
        port[0] = '0;
        port[1] = 8'h01;
        #1;
        check("async_reset_irq_dut0", {31'b0, irq[0]}, 32'h0);
        check("async_reset_irq_dut1", {31'b0, irq[1]}, 32'h0);
        check("async_reset_rd_dut0", rd[0], 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = n_main; i < n_post; i++) run_vec(i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
